// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
//   Shared types and constants for the 3-digit time-multiplexed
//   7-segment scan driver.
//   - scan_state_t : blank gap / digit lit
//   - NUM_DIGITS   : number of scanned digits
//   - DIG_*        : digit index of each decimal position
//   - SEG_DARK     : segment pattern with nothing lit (internal lit-high encoding)
package seg_scan_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS   = 3;
  localparam int DIG_UNITS    = 0;
  localparam int DIG_TENS     = 1;
  localparam int DIG_HUNDREDS = 2;

  localparam logic [7:0] SEG_DARK = 8'h00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed scan driver for a common-bus 3-digit 7-segment display.
//   Each digit is preceded by a blanking gap; the displayed patterns come
//   from a shadow register that is only reloaded at the end of a frame, so
//   a value change never tears across digits.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     en           scan enable; 0 keeps the display dark
//     hundreds     segment pattern for digit 2 (bit0=a .. bit6=g, bit7=dp, 1=lit)
//     tens         segment pattern for digit 1
//     units        segment pattern for digit 0
//     upd          display-update request (load strobe of the peripheral)
//     seg          shared segment bus, polarity per ACTIVE_LOW
//     an           digit enables, one-hot when lit (an[0]=units)
//     frame_start  one-cycle pulse on the first lit cycle of digit 0
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] hundreds,
  input  logic [7:0] tens,
  input  logic [7:0] units,
  input  logic       upd,
  output logic [7:0] seg,
  output logic [2:0] an,
  output logic       frame_start
);

  localparam int MAX_CYCLES = max_int(DIGIT_CYCLES, BLANK_CYCLES);
  // Keep at least one bit so a degenerate 1-cycle configuration still elaborates.
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  localparam logic [1:0] IDX_UNITS    = 2'(DIG_UNITS);
  localparam logic [1:0] IDX_HUNDREDS = 2'(DIG_HUNDREDS);

  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0] AN_OFF  = ACTIVE_LOW ? 3'b111 : 3'b000;

  scan_state_t      state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       shadow_reg  [NUM_DIGITS];
  logic [7:0]       shadow_next [NUM_DIGITS];
  logic [7:0]       digit_in    [NUM_DIGITS];
  logic             pending_reg, pending_next;
  logic [7:0]       seg_reg, seg_next;
  logic [2:0]       an_reg, an_next;
  logic             frame_start_reg, frame_start_next;

  logic             capture_edge;
  logic [7:0]       seg_lit;
  logic [2:0]       an_lit;

  assign digit_in[DIG_UNITS]    = units;
  assign digit_in[DIG_TENS]     = tens;
  assign digit_in[DIG_HUNDREDS] = hundreds;

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;
    capture_edge = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shadow_next[i] = shadow_reg[i];
    end

    if (!en) begin
      // Disabled: park at the start of a frame; every edge is a capture
      // opportunity since nothing is being displayed.
      state_next   = S_BLANK;
      idx_next     = IDX_UNITS;
      cnt_next     = '0;
      capture_edge = 1'b1;
    end else begin
      case (state_reg)
        S_BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = S_ON;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_ON: begin
          if (cnt_reg == DIGIT_LAST) begin
            state_next = S_BLANK;
            cnt_next   = '0;
            if (idx_reg == IDX_HUNDREDS) begin
              idx_next     = IDX_UNITS;
              capture_edge = 1'b1;   // end of frame
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = S_BLANK;
          idx_next   = IDX_UNITS;
          cnt_next   = '0;
        end
      endcase
    end

    // Requests between frame boundaries are remembered and merged; the
    // values loaded are whatever is on the inputs at the capture edge.
    if (capture_edge && (pending_reg || upd)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_next[i] = digit_in[i];
      end
      pending_next = 1'b0;
    end else if (upd) begin
      pending_next = 1'b1;
    end

    // Outputs are registered from the next state so they line up with it.
    seg_lit = SEG_DARK;
    an_lit  = 3'b000;
    if (state_next == S_ON) begin
      seg_lit = shadow_next[idx_next];
      an_lit  = 3'b001 << idx_next;
    end
    seg_next = ACTIVE_LOW ? ~seg_lit : seg_lit;
    an_next  = ACTIVE_LOW ? ~an_lit  : an_lit;

    frame_start_next = (state_next == S_ON) && (idx_next == IDX_UNITS) &&
                       (cnt_next == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_BLANK;
      idx_reg         <= IDX_UNITS;
      cnt_reg         <= '0;
      pending_reg     <= 1'b0;
      seg_reg         <= SEG_OFF;
      an_reg          <= AN_OFF;
      frame_start_reg <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_reg[i] <= SEG_DARK;
      end
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      cnt_reg         <= cnt_next;
      pending_reg     <= pending_next;
      seg_reg         <= seg_next;
      an_reg          <= an_next;
      frame_start_reg <= frame_start_next;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_reg[i] <= shadow_next[i];
      end
    end
  end

  assign seg         = seg_reg;
  assign an          = an_reg;
  assign frame_start = frame_start_reg;

endmodule
